// File: rtl/bist_seq_controller.sv
// bist_seq_controller: BIST sequencer for a 4-input / 1-output benchmark netlist.
// It flushes the netlist with INIT_VEC, applies NUM_PATTERNS vectors from a
// 4-bit Fibonacci LFSR, and compacts the response in an 8-bit Galois MISR.
// The final signature is then checked against cfg_golden.
module bist_seq_controller #(
  parameter int unsigned NUM_PATTERNS = 64,
  parameter int unsigned INIT_CYCLES  = 4,
  parameter logic [3:0]  INIT_VEC     = 4'b0000,
  parameter logic [3:0]  LFSR_SEED    = 4'b0001,
  parameter logic [7:0]  MISR_POLY    = 8'h1D
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cfg_golden,
  output logic [3:0] dut_in,
  input  logic       dut_f,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature
);

  localparam int unsigned IW = $clog2(INIT_CYCLES + 1);
  localparam int unsigned PW = $clog2(NUM_PATTERNS + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [PW-1:0] PAT_LAST  = PW'(NUM_PATTERNS - 1);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [3:0] SEED = (LFSR_SEED == 4'b0000) ? 4'b0001 : LFSR_SEED;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [3:0]    r_dut_in;
  logic [3:0]    r_lfsr;      // value that the next RUN cycle will drive
  logic [7:0]    r_sig;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;
  logic [IW-1:0] r_init_cnt;
  logic [PW-1:0] r_pat_cnt;

  logic [3:0]    w_lfsr_next;
  logic [7:0]    w_misr_next;

  // Next-state functions of the pattern generator and the response compactor.
  assign w_lfsr_next = {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
  assign w_misr_next = {r_sig[6:0], 1'b0}
                     ^ (r_sig[7] ? MISR_POLY : 8'h00)
                     ^ {7'b0, dut_f};

  // Sequencer: one FSM with every output registered on the state edge.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, e.g. the MISR uses the signature of this cycle.
  always_ff @(posedge clock) begin
    if (!rst_n || abort) begin
      r_state    <= S_IDLE;
      r_dut_in   <= INIT_VEC;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_lfsr     <= SEED;
      r_init_cnt <= '0;
      r_pat_cnt  <= '0;
      // An abort leaves the partial signature visible for debug.
      if (!rst_n) r_sig <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_INIT;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_sig      <= '0;
            r_lfsr     <= SEED;
            r_init_cnt <= '0;
            r_dut_in   <= INIT_VEC;
          end
        end
        S_INIT: begin
          if (r_init_cnt == INIT_LAST) begin
            r_state   <= S_RUN;
            r_pat_cnt <= '0;
            r_dut_in  <= r_lfsr;
            r_lfsr    <= w_lfsr_next;
          end else begin
            r_init_cnt <= r_init_cnt + IW'(1);
          end
        end
        S_RUN: begin
          r_sig <= w_misr_next;
          if (r_pat_cnt == PAT_LAST) begin
            r_state  <= S_COMPARE;
            r_dut_in <= INIT_VEC;
          end else begin
            r_pat_cnt <= r_pat_cnt + PW'(1);
            r_dut_in  <= r_lfsr;
            r_lfsr    <= w_lfsr_next;
          end
        end
        S_COMPARE: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (r_sig == cfg_golden);
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dut_in    = r_dut_in;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_sig;

endmodule

// File: tb/tb_bist_seq_controller.sv
// Bench for bist_seq_controller. Instance A uses the default INIT_CYCLES=4 with
// NUM_PATTERNS=8; instance B (INIT_CYCLES=1, NUM_PATTERNS=16) exposes the full
// LFSR sequence. Expected done events and RUN vectors are queued by the
// stimulus and popped by monitors when the DUT presents them.
module tb_bist_seq_controller;

  localparam int A_INIT = 4;
  localparam int A_NUM  = 8;

  typedef struct {
    logic [7:0] sig;
    logic       pass;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a;
  logic       start_b;
  logic       abort;
  logic [7:0] cfg_golden;
  logic       dut_f;
  logic [3:0] dut_in_a, dut_in_b;
  logic       busy_a, done_a, pass_a;
  logic       busy_b, done_b, pass_b;
  logic [7:0] sig_a, sig_b;

  int   f_mode = 1;   // 0: f=0, 1: f=1, 2: f = bit d of instance A's vector
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  exp_t       sb_a[$];
  logic [3:0] sb_b[$];
  exp_t       e_a;
  logic       done_a_q = 1'b0;

  logic [7:0] exp_steps [8] = '{8'h01, 8'h03, 8'h07, 8'h0F,
                                8'h1F, 8'h3F, 8'h7F, 8'hFF};
  logic [3:0] exp_lfsr [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in netlist response.
  always_comb begin
    case (f_mode)
      0:       dut_f = 1'b0;
      1:       dut_f = 1'b1;
      default: dut_f = dut_in_a[0];
    endcase
  end

  bist_seq_controller #(
    .NUM_PATTERNS(A_NUM),
    .INIT_CYCLES (A_INIT)
  ) u_dut_a (
    .clock     (clk),
    .rst_n     (rst_n),
    .start     (start_a),
    .abort     (abort),
    .cfg_golden(cfg_golden),
    .dut_in    (dut_in_a),
    .dut_f     (dut_f),
    .busy      (busy_a),
    .done      (done_a),
    .pass      (pass_a),
    .signature (sig_a)
  );

  bist_seq_controller #(
    .NUM_PATTERNS(16),
    .INIT_CYCLES (1)
  ) u_dut_b (
    .clock     (clk),
    .rst_n     (rst_n),
    .start     (start_b),
    .abort     (1'b0),
    .cfg_golden(8'h00),
    .dut_in    (dut_in_b),
    .dut_f     (dut_f),
    .busy      (busy_b),
    .done      (done_b),
    .pass      (pass_b),
    .signature (sig_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step after the start edge, i.e. in relative cycle 1.
  task automatic start_pulse(input bit with_b);
    start_a = 1'b1;
    start_b = with_b;
    step(1);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Called in relative cycle 1; done is seen in cycle INIT+NUM+2.
  task automatic expect_run(input logic [7:0] sig, input logic p);
    exp_t e;
    e.sig  = sig;
    e.pass = p;
    e.cyc  = cyc + A_INIT + A_NUM + 1;
    sb_a.push_back(e);
  endtask

  // Monitor A: every rising done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done_a && !done_a_q) begin
      if (sb_a.size() == 0) begin
        check("done_a_unexpected", 32'(done_a), 32'(0));
      end else begin
        e_a = sb_a.pop_front();
        check("final_signature", 32'(sig_a), 32'(e_a.sig));
        check("pass", 32'(pass_a), 32'(e_a.pass));
        check("done_cycle", cyc, e_a.cyc);
      end
    end
    done_a_q <= done_a;
  end

  // Monitor B: the LFSR never produces 0, so a non-zero vector means RUN.
  always @(negedge clk) begin
    if (rst_n && dut_in_b != 4'h0) begin
      if (sb_b.size() == 0) check("dut_in_b_unexpected", 32'(dut_in_b), 32'(0));
      else check("lfsr_vector", 32'(dut_in_b), 32'(sb_b.pop_front()));
    end
  end

  initial begin
    rst_n      = 1'b0;
    start_a    = 1'b0;
    start_b    = 1'b0;
    abort      = 1'b0;
    cfg_golden = 8'h00;
    step(3);
    check("rst_busy", 32'(busy_a), 32'(0));
    check("rst_done", 32'(done_a), 32'(0));
    check("rst_pass", 32'(pass_a), 32'(0));
    check("rst_signature", 32'(sig_a), 32'(0));
    check("rst_dut_in", 32'(dut_in_a), 32'(0));
    rst_n = 1'b1;
    step(2);

    // Run 1: f=1, golden FF; B runs alongside for the LFSR sequence.
    for (int i = 0; i < 16; i++) sb_b.push_back(exp_lfsr[i]);
    f_mode     = 1;
    cfg_golden = 8'hFF;
    start_pulse(1'b1);
    expect_run(8'hFF, 1'b1);
    check("init_dut_in", 32'(dut_in_a), 32'(0));
    step(5);
    for (int k = 0; k < 8; k++) begin
      check("sig_step", 32'(sig_a), 32'(exp_steps[k]));
      if (k == 5) check("sig_9th_step", 32'(sig_b), 32'(8'hE2));
      if (k < 7) step(1);
    end
    check("busy_in_compare", 32'(busy_a), 32'(1));
    check("done_before_end", 32'(done_a), 32'(0));
    step(1);
    check("done_cycle14", 32'(done_a), 32'(1));
    step(8);
    check("done_held", 32'(done_a), 32'(1));
    check("pass_held", 32'(pass_a), 32'(1));

    // Run 2: same stream, wrong golden.
    cfg_golden = 8'hFE;
    start_pulse(1'b0);
    expect_run(8'hFF, 1'b0);
    step(13);
    check("fail_done", 32'(done_a), 32'(1));
    check("fail_pass", 32'(pass_a), 32'(0));
    step(2);

    // Run 3: restart from DONE with the netlist stream; start pulses while busy.
    f_mode     = 2;
    cfg_golden = 8'h9A;
    start_pulse(1'b0);
    expect_run(8'h9A, 1'b1);
    check("restart_done_clr", 32'(done_a), 32'(0));
    check("restart_pass_clr", 32'(pass_a), 32'(0));
    check("restart_misr_clr", 32'(sig_a), 32'(0));
    step(1);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    step(5);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    step(7);
    check("busy_start_done", 32'(done_a), 32'(1));
    step(2);

    // Run 4: identical stream from DONE gives identical result and timing.
    start_pulse(1'b0);
    expect_run(8'h9A, 1'b1);
    step(15);

    // Abort in RUN cycle 3 (relative cycle 7).
    f_mode = 1;
    start_pulse(1'b0);
    step(6);
    check("pre_abort_sig", 32'(sig_a), 32'(8'h03));
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_busy", 32'(busy_a), 32'(0));
    check("abort_dut_in", 32'(dut_in_a), 32'(0));
    check("abort_sig_held", 32'(sig_a), 32'(8'h03));
    step(20);
    check("abort_sig_still", 32'(sig_a), 32'(8'h03));
    check("abort_no_done", 32'(done_a), 32'(0));

    // start together with abort in IDLE.
    start_a = 1'b1;
    abort   = 1'b1;
    step(1);
    start_a = 1'b0;
    abort   = 1'b0;
    check("abort_start_idle", 32'(busy_a), 32'(0));
    step(5);
    check("abort_start_still", 32'(busy_a), 32'(0));

    // Reset in relative cycle 10.
    start_pulse(1'b0);
    step(9);
    check("pre_reset_sig", 32'(sig_a), 32'(8'h1F));
    check("pre_reset_busy", 32'(busy_a), 32'(1));
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("midrun_rst_busy", 32'(busy_a), 32'(0));
    check("midrun_rst_dut_in", 32'(dut_in_a), 32'(0));
    check("midrun_rst_sig", 32'(sig_a), 32'(0));
    step(20);
    check("midrun_rst_no_done", 32'(done_a), 32'(0));

    check("sb_a_pending", sb_a.size(), 0);
    check("sb_b_pending", sb_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
